// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction, ALU and result signals of alu_sequencer.
// ALU_SEQ_STATUS_EN adds the OpCount/ZeroCount status outputs.
interface alu_sequencer_if;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instr;

    logic [7:0]  AluA;
    logic [7:0]  AluB;
    logic [2:0]  AluOp;
    logic [7:0]  AluResult;
    logic        AluZero;
    logic        AluCarry;

    logic        ResValid;
    logic        ResReady;
    logic [7:0]  ResData;
    logic        ResZero;
    logic        ResCarry;

`ifdef ALU_SEQ_STATUS_EN
    logic [15:0] OpCount;
    logic [15:0] ZeroCount;

    modport master (
        output InstrValid, Instr,
        input  InstrReady,
        input  AluA, AluB, AluOp,
        output AluResult, AluZero, AluCarry,
        input  ResValid, ResData, ResZero, ResCarry,
        output ResReady,
        input  OpCount, ZeroCount
    );

    modport slave (
        input  InstrValid, Instr,
        output InstrReady,
        output AluA, AluB, AluOp,
        input  AluResult, AluZero, AluCarry,
        output ResValid, ResData, ResZero, ResCarry,
        input  ResReady,
        output OpCount, ZeroCount
    );
`else
    modport master (
        output InstrValid, Instr,
        input  InstrReady,
        input  AluA, AluB, AluOp,
        output AluResult, AluZero, AluCarry,
        input  ResValid, ResData, ResZero, ResCarry,
        output ResReady
    );

    modport slave (
        input  InstrValid, Instr,
        output InstrReady,
        output AluA, AluB, AluOp,
        input  AluResult, AluZero, AluCarry,
        output ResValid, ResData, ResZero, ResCarry,
        input  ResReady
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue control stage feeding an 8-bit ALU, 4x8 register file.
// Define ALU_SEQ_STATUS_EN to add the OpCount/ZeroCount status counters.
module alu_sequencer #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] rf [4];

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [1:0] dst;

    logic [7:0] res_data;
    logic       res_zero;
    logic       res_carry;

    logic       is_imm;
    logic [1:0] imm_dst;
    logic [7:0] imm_val;
    logic [2:0] dec_op;
    logic [1:0] dec_dst;
    logic [1:0] dec_src_a;
    logic [1:0] dec_src_b;

    logic       instr_ready;
    logic       res_valid;
    logic       load_imm;
    logic       issue;
    logic       capture;

    assign is_imm    = bus.Instr[15];
    assign imm_dst   = bus.Instr[9:8];
    assign imm_val   = bus.Instr[7:0];
    assign dec_op    = bus.Instr[14:12];
    assign dec_dst   = bus.Instr[11:10];
    assign dec_src_a = bus.Instr[9:8];
    assign dec_src_b = bus.Instr[7:6];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.InstrValid && !is_imm) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WB;
            end
            WB: begin
                if (bus.ResReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // InstrReady is forced low while reset is held, even though state is IDLE
    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        load_imm    = 1'b0;
        issue       = 1'b0;
        capture     = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = !reset;
                load_imm    = bus.InstrValid && is_imm;
                issue       = bus.InstrValid && !is_imm;
            end
            EXEC: begin
                capture = 1'b1;
            end
            WB: begin
                res_valid = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= REG_INIT;
            end
        end else begin
            unique case (1'b1)
                load_imm: rf[imm_dst] <= imm_val;
                capture:  rf[dst]     <= bus.AluResult;
                default:  ;
            endcase
        end
    end

    // Operands latched at accept, so aliased Dst never disturbs the reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
            alu_op <= 3'd0;
            dst    <= 2'd0;
        end else if (issue) begin
            alu_a  <= rf[dec_src_a];
            alu_b  <= rf[dec_src_b];
            alu_op <= dec_op;
            dst    <= dec_dst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data  <= 8'h00;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
        end else if (capture) begin
            res_data  <= bus.AluResult;
            res_zero  <= bus.AluZero;
            res_carry <= bus.AluCarry;
        end
    end

`ifdef ALU_SEQ_STATUS_EN
    logic        retire;
    logic [15:0] op_count;
    logic [15:0] zero_count;

    assign retire = res_valid && bus.ResReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count   <= 16'd0;
            zero_count <= 16'd0;
        end else if (retire) begin
            op_count <= op_count + 16'd1;
            if (res_zero) begin
                zero_count <= zero_count + 16'd1;
            end
        end
    end

    assign bus.OpCount   = op_count;
    assign bus.ZeroCount = zero_count;
`endif

    assign bus.InstrReady = instr_ready;
    assign bus.AluA       = alu_a;
    assign bus.AluB       = alu_b;
    assign bus.AluOp      = alu_op;
    assign bus.ResValid   = res_valid;
    assign bus.ResData    = res_data;
    assign bus.ResZero    = res_zero;
    assign bus.ResCarry   = res_carry;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Single-issue control stage directly upstream of the 8-bit combinational ALU. It accepts encoded instructions over a valid/ready handshake and holds a 4-entry x 8-bit register file. It drives the ALU operand and opcode inputs, captures Result/Zero/Carry, writes the result back, and presents it downstream over a second valid/ready handshake.

## Interface
- REG_INIT, 8'h00, reset value of every register-file entry
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- InstrValid  in  1  upstream instruction valid
- InstrReady  out  1  high only in IDLE
- Instr  in  16  [15]=Imm; Imm=1: [9:8] Dst, [7:0] immediate; Imm=0: [14:12] Opcode, [11:10] Dst, [9:8] SrcA, [7:6] SrcB; other bits ignored
- AluA, AluB  out  8 each  registered operands to ALU A/B
- AluOp  out  3  registered opcode to ALU Opcode
- AluResult  in  8  ALU Result
- AluZero, AluCarry  in  1 each  ALU flags
- ResValid  out  1  result available
- ResReady  in  1  downstream accepts result
- ResData  out  8  captured result
- ResZero, ResCarry  out  1 each  captured flags

## Operation
- States: IDLE, EXEC, WB; reset state IDLE.
- IDLE: InstrReady=1. On InstrValid, Imm=1: rf[Dst] <= immediate at the same edge; stay IDLE; no result handshake.
- IDLE: on InstrValid, Imm=0: AluA <= rf[SrcA], AluB <= rf[SrcB], AluOp <= Opcode, latch Dst; go EXEC.
- EXEC: one cycle; ALU settles combinationally. At the edge: ResData <= AluResult, ResZero <= AluZero, ResCarry <= AluCarry, rf[Dst] <= AluResult; go WB.
- WB: ResValid=1, outputs held stable until ResReady=1. On that edge go IDLE.
- SrcA, SrcB and Dst may alias. Reads use pre-write values because the operands are latched in IDLE.
- AluA/AluB/AluOp hold their last values outside EXEC. ResData/flags hold until the next EXEC capture.
- No arithmetic in this block; 8-bit widths pass through. Carry semantics belong to the ALU: the ALU drives Carry=0 for ops 010-111.

## Timing
- Reset values: InstrReady=0 while reset is asserted, then 1 (IDLE); ResValid=0; AluA=AluB=0; AluOp=0; ResData=0; ResZero=0; ResCarry=0; all rf entries REG_INIT.
- ALU op latency: accept at edge t, result written at t+1, ResValid high from t+1.
- With ResReady tied high: one ALU op per 3 cycles, ResValid pulses for 1 cycle.
- Immediate load: one per cycle, written at the accept edge.
- Back-to-back dependent ops need no stall. The write at the EXEC edge precedes the next IDLE read.
- ResReady low in WB: the block stalls indefinitely and InstrReady stays 0.
- ResReady asserted outside WB is ignored.
- Reset asserted mid-EXEC or mid-WB: immediate return to IDLE with all outputs at their reset values. The pending rf write is lost.

## Configuration
- ALU_SEQ_STATUS_EN defined adds two outputs:
  - OpCount  out  16  increments on each WB handshake, wraps FFFF->0000.
  - ZeroCount  out  16  increments on handshakes with ResZero=1, wraps.
  - Both reset to 0. Immediate loads do not count.
- ALU_SEQ_STATUS_EN undefined: both ports and both counters are absent; all other behaviour is identical.

## Test plan
- Reset check: reset during WB -> next cycle ResValid=0, InstrReady=1, rf reads back REG_INIT.
- Load r0=8'hF0, r1=8'h20; ADD r2=r0+r1 with ResReady=1 -> ResData=8'h10, ResCarry=1, ResZero=0, ResValid for exactly 1 cycle, 3 cycles from accept to next InstrReady.
- SUB r3=r1-r1 -> ResData=8'h00, ResZero=1; then XOR r3=r3^r0 issued back-to-back -> ResData=8'hF0 (dependent result used without stall).
- Stall: hold ResReady=0 for 5 cycles after ADD -> ResValid and ResData stable, InstrReady=0 throughout; release -> IDLE next cycle.
- Aliasing: SHL r0=r0<<1 with r0=8'h81 -> ResData=8'h02, ResCarry=0, r0=8'h02 afterwards.
- With ALU_SEQ_STATUS_EN: 3 ops, one zero result, plus 2 immediate loads -> OpCount=3, ZeroCount=1.
